avaliador_sequencia: RTL and testbench
======================================

Name: avaliador_sequencia

Overview:
Parametrised successor of the piano datapath. A self-contained sequence engine with two modes: record a played sequence (note + duration) into internal memory, or evaluate a player against the stored sequence. Evaluation scores note and timing with a configurable tolerance and counts hits and errors. It sits between the button matrix and the top-level FSM and replaces the separate note/tempo memories, metronomes, timeout timer and comparators.

Parameters:
CLOCK_FREQ, 50000000, clock frequency in Hz.
N_BOTOES, 12, number of note buttons. NOTE_W = $clog2(N_BOTOES+1).
DEPTH, 16, number of sequence entries. ADDR_W = $clog2(DEPTH).
TEMPO_W, 4, width of a stored duration, in ticks.
TOL, 1, allowed timing error, in ticks either side.
TICK_LENTO, CLOCK_FREQ/2, clock cycles per tick in slow mode.
TICK_RAPIDO, CLOCK_FREQ/4, clock cycles per tick in fast mode.
TIMEOUT_TICKS, 10, ticks without a press before timeout.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
iniciar  in  1  start pulse; ignored while ocupado=1.
modo_grava  in  1  sampled at start: 1 = record, 0 = evaluate.
rapido  in  1  sampled at start: 1 = TICK_RAPIDO, 0 = TICK_LENTO.
ultimo  in  ADDR_W  index of the last entry to process (length = ultimo+1).
botoes  in  N_BOTOES  one bit per key.
ocupado  out  1  high from start until FIM.
pronto  out  1  one-cycle pulse on entering FIM.
resultado_valido  out  1  one-cycle pulse per evaluated note.
nota_ok  out  1  valid with resultado_valido.
tempo_ok  out  1  valid with resultado_valido.
timeout  out  1  sticky; set on timeout, cleared at next start.
endereco  out  ADDR_W  current entry index.
acertos  out  ADDR_W+1  notes with both nota_ok and tempo_ok.
erros  out  ADDR_W+1  evaluated notes failing either check.
tick  out  1  one-cycle metronome pulse, for LED/buzzer.
db_estado  out  3  FSM state code.

Behaviour:
- Reset (reset=0 at an edge) applies at any time, including mid-sequence:
  - FSM goes to OCIOSO.
  - All outputs and counters go to 0.
  - Memory contents are retained (memory is not reset).
- Note encoding: value = 1 + index of the lowest set bit of botoes; 0 means no key. With several keys down, the lowest index wins.
- Press event: |botoes is 1 at edge k and was 0 at edge k-1. The encoded note is captured at edge k. Holding a key produces one event only.
- Tick generator:
  - Counter is cleared at start and at every press event.
  - tick pulses each period; the period is selected by rapido as latched at start.
  - Elapsed-tick counter `medido` counts ticks since the last press (or since start) and saturates at 2^TEMPO_W-1.
- FSM states:
  - OCIOSO: on iniciar → ESPERA. Latch the mode inputs; clear endereco, acertos, erros, timeout and the tick counters.
  - ESPERA: on a press event → AVALIA. If the timeout counter reaches TIMEOUT_TICKS → set timeout, go to FIM.
  - AVALIA, record mode: write {nota, medido} at endereco. Entry 0 always stores duration 0. Then → PROXIMO.
  - AVALIA, evaluate mode:
    - Read entry at endereco.
    - nota_ok = (captured note == stored note).
    - tempo_ok = |medido − stored duration| ≤ TOL. Always 1 for entry 0.
    - Pulse resultado_valido; update acertos or erros. Then → PROXIMO.
  - PROXIMO: if endereco == ultimo → FIM; else increment endereco → ESPERA.
  - FIM: pulse pronto, clear ocupado → OCIOSO.
- Latency: resultado_valido is high for exactly the cycle after edge k+1 (2 cycles after the press edge).
- Press events outside ESPERA are ignored.
- A timeout in record mode is normal termination: entries 0..endereco−1 are valid and endereco reports how many were recorded.
- acertos + erros == number of resultado_valido pulses since start.
- endereco never wraps past ultimo.
- iniciar held high through FIM causes an immediate restart from OCIOSO.

Test Plan:
(All cases use CLOCK_FREQ=8, so TICK_LENTO=4 and TICK_RAPIDO=2 cycles; TOL=1; TIMEOUT_TICKS=10; DEPTH=16.)
1. Record with ultimo=2, slow mode: press key 3 at t0, key 5 after 12 cycles, key 0 after 8 more → memory = {4,0},{6,3},{1,2}; pronto pulses once; endereco=2.
2. Evaluate the same sequence with identical timing → three resultado_valido pulses, each with nota_ok=tempo_ok=1; acertos=3, erros=0.
3. Evaluate, second press arrives 20 cycles after the first (medido=5 vs stored 3) → tempo_ok=0, nota_ok=1; erros=1.
4. Evaluate, keys 2 and 7 pressed together for entry 0 storing note 3 → captured note 3, nota_ok=1.
5. No press for 40 cycles in ESPERA → timeout=1, pronto pulses, ocupado=0; the next iniciar clears timeout.
6. Drive reset=0 during AVALIA, release, then evaluate again → counters restart from 0; stored memory still matches case 1.

Source files
------------

// File: rtl/avaliador_sequencia.sv
// ---------------------------------------------------------------------------
// avaliador_sequencia
//
// Sequence engine for the piano game. In record mode it stores a played
// sequence (note + duration in metronome ticks) in an internal memory; in
// evaluate mode it scores a player against the stored sequence, checking the
// note and the timing (within +/-TOL ticks) and counting hits and errors.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous, active-low reset (memory is not reset)
//   iniciar          start pulse, ignored while ocupado=1
//   modo_grava       latched at start: 1 = record, 0 = evaluate
//   rapido           latched at start: 1 = fast tick, 0 = slow tick
//   ultimo           index of the last entry to process
//   botoes           one bit per key
//   ocupado          high from start until the sequence ends
//   pronto           one-cycle pulse on entering FIM
//   resultado_valido one-cycle pulse per evaluated note
//   nota_ok/tempo_ok per-note result, valid with resultado_valido
//   timeout          sticky timeout flag, cleared at next start
//   endereco         current entry index
//   acertos/erros    hit / miss counters
//   tick             one-cycle metronome pulse
//   db_estado        FSM state code
// ---------------------------------------------------------------------------
module avaliador_sequencia #(
    parameter int CLOCK_FREQ    = 50000000,
    parameter int N_BOTOES      = 12,
    parameter int DEPTH         = 16,
    parameter int TEMPO_W       = 4,
    parameter int TOL           = 1,
    parameter int TICK_LENTO    = CLOCK_FREQ / 2,
    parameter int TICK_RAPIDO   = CLOCK_FREQ / 4,
    parameter int TIMEOUT_TICKS = 10,
    localparam int NOTE_W       = $clog2(N_BOTOES + 1),
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                modo_grava,
    input  logic                rapido,
    input  logic [ADDR_W-1:0]   ultimo,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                ocupado,
    output logic                pronto,
    output logic                resultado_valido,
    output logic                nota_ok,
    output logic                tempo_ok,
    output logic                timeout,
    output logic [ADDR_W-1:0]   endereco,
    output logic [ADDR_W:0]     acertos,
    output logic [ADDR_W:0]     erros,
    output logic                tick,
    output logic [2:0]          db_estado
);

    localparam int TICK_MAX = (TICK_LENTO > TICK_RAPIDO) ? TICK_LENTO : TICK_RAPIDO;
    localparam int CNT_W    = $clog2(TICK_MAX + 1);
    localparam int TO_W     = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [CNT_W-1:0]   LENTO_FIM  = CNT_W'(TICK_LENTO - 1);
    localparam logic [CNT_W-1:0]   RAPIDO_FIM = CNT_W'(TICK_RAPIDO - 1);
    localparam logic [TO_W-1:0]    TO_LIMITE  = TO_W'(TIMEOUT_TICKS);
    localparam logic [TEMPO_W-1:0] MEDIDO_MAX = {TEMPO_W{1'b1}};
    localparam logic [TEMPO_W:0]   TOL_LIM    = (TEMPO_W + 1)'(TOL);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        ESPERA  = 3'd1,
        AVALIA  = 3'd2,
        PROXIMO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    // Priority encoder: lowest pressed key wins, 0 means no key.
    function automatic logic [NOTE_W-1:0] codifica(input logic [N_BOTOES-1:0] b);
        logic [NOTE_W-1:0] n;
        n = {NOTE_W{1'b0}};
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (b[i]) begin
                n = NOTE_W'(i + 1);
            end
        end
        return n;
    endfunction

    estado_t              estado_r;
    logic                 modo_r;
    logic                 rapido_r;
    logic [ADDR_W-1:0]    ultimo_r;
    logic [ADDR_W-1:0]    endereco_r;
    logic [ADDR_W:0]      acertos_r;
    logic [ADDR_W:0]      erros_r;
    logic                 ocupado_r;
    logic                 pronto_r;
    logic                 rv_r;
    logic                 nota_ok_r;
    logic                 tempo_ok_r;
    logic                 timeout_r;
    logic [NOTE_W-1:0]    nota_cap_r;
    logic [TEMPO_W-1:0]   medido_cap_r;
    logic                 prev_any_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [TEMPO_W-1:0]   medido_r;
    logic [TO_W-1:0]      to_cnt_r;
    logic                 tick_r;

    logic [NOTE_W-1:0]    mem_nota_r  [DEPTH];
    logic [TEMPO_W-1:0]   mem_tempo_r [DEPTH];

    logic                 press_s;
    logic [CNT_W-1:0]     fim_periodo_s;
    logic                 tick_now_s;
    logic [TEMPO_W-1:0]   medido_next_s;
    logic [TEMPO_W-1:0]   diff_s;
    logic                 nota_ok_s;
    logic                 tempo_ok_s;
    logic                 we_s;

    // Press detection, tick bookkeeping and per-entry comparison.
    always_comb begin
        press_s       = (|botoes) & ~prev_any_r;
        fim_periodo_s = rapido_r ? RAPIDO_FIM : LENTO_FIM;
        tick_now_s    = (cnt_r == fim_periodo_s);
        // Include a tick landing on this very edge so the captured duration
        // counts every full period since the previous press.
        if (tick_now_s && (medido_r != MEDIDO_MAX)) begin
            medido_next_s = medido_r + TEMPO_W'(1);
        end else begin
            medido_next_s = medido_r;
        end
        if (medido_cap_r >= mem_tempo_r[endereco_r]) begin
            diff_s = medido_cap_r - mem_tempo_r[endereco_r];
        end else begin
            diff_s = mem_tempo_r[endereco_r] - medido_cap_r;
        end
        nota_ok_s  = (nota_cap_r == mem_nota_r[endereco_r]);
        tempo_ok_s = (endereco_r == {ADDR_W{1'b0}}) || ({1'b0, diff_s} <= TOL_LIM);
        we_s       = (estado_r == AVALIA) && modo_r;
    end

    // Previous key-activity flag for edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_any_r <= 1'b0;
        end else begin
            prev_any_r <= |botoes;
        end
    end

    // Metronome: period counter, tick pulse, elapsed ticks and timeout ticks.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            medido_r <= {TEMPO_W{1'b0}};
            to_cnt_r <= {TO_W{1'b0}};
            tick_r   <= 1'b0;
        end else if ((estado_r == OCIOSO) || press_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            medido_r <= {TEMPO_W{1'b0}};
            to_cnt_r <= {TO_W{1'b0}};
            tick_r   <= 1'b0;
        end else if (tick_now_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            tick_r   <= 1'b1;
            medido_r <= medido_next_s;
            if (to_cnt_r != TO_LIMITE) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            tick_r <= 1'b0;
        end
    end

    // Sequence memory; intentionally survives reset.
    always_ff @(posedge clock) begin
        if (we_s && reset) begin
            mem_nota_r[endereco_r] <= nota_cap_r;
            if (endereco_r == {ADDR_W{1'b0}}) begin
                mem_tempo_r[endereco_r] <= {TEMPO_W{1'b0}};
            end else begin
                mem_tempo_r[endereco_r] <= medido_cap_r;
            end
        end
    end

    // Main control FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_r     <= OCIOSO;
            modo_r       <= 1'b0;
            rapido_r     <= 1'b0;
            ultimo_r     <= {ADDR_W{1'b0}};
            endereco_r   <= {ADDR_W{1'b0}};
            acertos_r    <= {(ADDR_W + 1){1'b0}};
            erros_r      <= {(ADDR_W + 1){1'b0}};
            ocupado_r    <= 1'b0;
            pronto_r     <= 1'b0;
            rv_r         <= 1'b0;
            nota_ok_r    <= 1'b0;
            tempo_ok_r   <= 1'b0;
            timeout_r    <= 1'b0;
            nota_cap_r   <= {NOTE_W{1'b0}};
            medido_cap_r <= {TEMPO_W{1'b0}};
        end else begin
            pronto_r <= 1'b0;
            rv_r     <= 1'b0;
            case (estado_r)
                OCIOSO: begin
                    if (iniciar) begin
                        modo_r     <= modo_grava;
                        rapido_r   <= rapido;
                        ultimo_r   <= ultimo;
                        endereco_r <= {ADDR_W{1'b0}};
                        acertos_r  <= {(ADDR_W + 1){1'b0}};
                        erros_r    <= {(ADDR_W + 1){1'b0}};
                        timeout_r  <= 1'b0;
                        ocupado_r  <= 1'b1;
                        estado_r   <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (press_s) begin
                        nota_cap_r   <= codifica(botoes);
                        medido_cap_r <= medido_next_s;
                        estado_r     <= AVALIA;
                    end else if (to_cnt_r == TO_LIMITE) begin
                        timeout_r <= 1'b1;
                        pronto_r  <= 1'b1;
                        ocupado_r <= 1'b0;
                        estado_r  <= FIM;
                    end
                end
                AVALIA: begin
                    if (!modo_r) begin
                        rv_r       <= 1'b1;
                        nota_ok_r  <= nota_ok_s;
                        tempo_ok_r <= tempo_ok_s;
                        if (nota_ok_s && tempo_ok_s) begin
                            acertos_r <= acertos_r + (ADDR_W + 1)'(1);
                        end else begin
                            erros_r <= erros_r + (ADDR_W + 1)'(1);
                        end
                    end
                    estado_r <= PROXIMO;
                end
                PROXIMO: begin
                    if (endereco_r == ultimo_r) begin
                        pronto_r  <= 1'b1;
                        ocupado_r <= 1'b0;
                        estado_r  <= FIM;
                    end else begin
                        endereco_r <= endereco_r + ADDR_W'(1);
                        estado_r   <= ESPERA;
                    end
                end
                FIM: begin
                    estado_r <= OCIOSO;
                end
                default: begin
                    ocupado_r <= 1'b0;
                    estado_r  <= OCIOSO;
                end
            endcase
        end
    end

    assign ocupado          = ocupado_r;
    assign pronto           = pronto_r;
    assign resultado_valido = rv_r;
    assign nota_ok          = nota_ok_r;
    assign tempo_ok         = tempo_ok_r;
    assign timeout          = timeout_r;
    assign endereco         = endereco_r;
    assign acertos          = acertos_r;
    assign erros            = erros_r;
    assign tick             = tick_r;
    assign db_estado        = estado_r;

endmodule

// File: tb/tb_avaliador_sequencia.sv
// ---------------------------------------------------------------------------
// tb_avaliador_sequencia
//
// Directed bench for avaliador_sequencia with CLOCK_FREQ=8 (slow tick = 4
// cycles, fast tick = 2 cycles), TOL=1, TIMEOUT_TICKS=10, DEPTH=16.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_avaliador_sequencia;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic        modo_grava;
    logic        rapido;
    logic [3:0]  ultimo;
    logic [11:0] botoes;
    logic        ocupado;
    logic        pronto;
    logic        resultado_valido;
    logic        nota_ok;
    logic        tempo_ok;
    logic        timeout;
    logic [3:0]  endereco;
    logic [4:0]  acertos;
    logic [4:0]  erros;
    logic        tick;
    logic [2:0]  db_estado;

    int total = 0;
    int bad   = 0;
    int rv_cnt = 0;
    int pronto_cnt = 0;

    avaliador_sequencia #(
        .CLOCK_FREQ    (8),
        .N_BOTOES      (12),
        .DEPTH         (16),
        .TEMPO_W       (4),
        .TOL           (1),
        .TIMEOUT_TICKS (10)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .iniciar          (iniciar),
        .modo_grava       (modo_grava),
        .rapido           (rapido),
        .ultimo           (ultimo),
        .botoes           (botoes),
        .ocupado          (ocupado),
        .pronto           (pronto),
        .resultado_valido (resultado_valido),
        .nota_ok          (nota_ok),
        .tempo_ok         (tempo_ok),
        .timeout          (timeout),
        .endereco         (endereco),
        .acertos          (acertos),
        .erros            (erros),
        .tick             (tick),
        .db_estado        (db_estado)
    );

    always #5 clock = ~clock;

    // Pulse counters sampled on the falling edge.
    always @(negedge clock) begin
        if (resultado_valido) rv_cnt++;
        if (pronto) pronto_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_start(input logic modo, input logic rap, input logic [3:0] ult);
        rv_cnt     = 0;
        pronto_cnt = 0;
        modo_grava = modo;
        rapido     = rap;
        ultimo     = ult;
        iniciar    = 1'b1;
        @(negedge clock);
        iniciar    = 1'b0;
    endtask

    // Drives a key mask for 'hold' cycles; reports outputs one and two
    // cycles after the press edge.
    task automatic press(input logic [11:0] mask, input int hold,
                         output logic rv0, output logic rv1,
                         output logic nok, output logic tok);
        botoes = mask;
        @(negedge clock);
        rv0 = resultado_valido;
        @(negedge clock);
        rv1 = resultado_valido;
        nok = nota_ok;
        tok = tempo_ok;
        repeat (hold - 2) @(negedge clock);
        botoes = 12'd0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        iniciar = 1'b0; modo_grava = 1'b0; rapido = 1'b0;
        ultimo = 4'd0; botoes = 12'd0;
        idle(3);
        reset = 1'b1;
        @(negedge clock);
        total++; if ({ocupado, pronto, resultado_valido, nota_ok, tempo_ok, timeout, tick} !== 7'd0) begin
            bad++; $display("FAIL reset_flags: got %b expected 0000000",
                {ocupado, pronto, resultado_valido, nota_ok, tempo_ok, timeout, tick}); end
        total++; if (endereco !== 4'd0 || acertos !== 5'd0 || erros !== 5'd0) begin
            bad++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", endereco, acertos, erros); end
        total++; if (db_estado !== 3'd0) begin
            bad++; $display("FAIL reset_state: got %0d expected 0", db_estado); end
    endtask

    task automatic check_memory(input string tag);
        logic [3:0] exp_n [3];
        logic [3:0] exp_t [3];
        exp_n = '{4'd4, 4'd6, 4'd1};
        exp_t = '{4'd0, 4'd3, 4'd2};
        for (int i = 0; i < 3; i++) begin
            total++; if (dut.mem_nota_r[i] !== exp_n[i] || dut.mem_tempo_r[i] !== exp_t[i]) begin
                bad++; $display("FAIL %s_mem%0d: got {%0d,%0d} expected {%0d,%0d}", tag, i,
                    dut.mem_nota_r[i], dut.mem_tempo_r[i], exp_n[i], exp_t[i]); end
        end
    endtask

    task automatic test_record;
        logic r0, r1, n, t;
        do_start(1'b1, 1'b0, 4'd2);
        total++; if (ocupado !== 1'b1 || db_estado !== 3'd1) begin
            bad++; $display("FAIL rec_start: got ocupado=%0b estado=%0d expected 1/1", ocupado, db_estado); end
        press(12'h008, 2, r0, r1, n, t); idle(10);
        press(12'h020, 2, r0, r1, n, t); idle(6);
        press(12'h001, 2, r0, r1, n, t); idle(3);
        total++; if (pronto_cnt !== 1 || ocupado !== 1'b0) begin
            bad++; $display("FAIL rec_done: got pronto_cnt=%0d ocupado=%0b expected 1/0", pronto_cnt, ocupado); end
        total++; if (endereco !== 4'd2 || rv_cnt !== 0) begin
            bad++; $display("FAIL rec_endereco: got %0d rv=%0d expected 2 rv=0", endereco, rv_cnt); end
        check_memory("rec");
    endtask

    task automatic test_evaluate;
        logic r0, r1, n, t;
        do_start(1'b0, 1'b0, 4'd2);
        press(12'h008, 2, r0, r1, n, t);
        total++; if (r0 !== 1'b0 || r1 !== 1'b1) begin
            bad++; $display("FAIL eval_latency: got %0b%0b expected 01", r0, r1); end
        total++; if (n !== 1'b1 || t !== 1'b1) begin
            bad++; $display("FAIL eval_e0: got nota=%0b tempo=%0b expected 1/1", n, t); end
        idle(10);
        press(12'h020, 2, r0, r1, n, t);
        total++; if (r1 !== 1'b1 || n !== 1'b1 || t !== 1'b1) begin
            bad++; $display("FAIL eval_e1: got rv=%0b nota=%0b tempo=%0b expected 1/1/1", r1, n, t); end
        idle(6);
        press(12'h001, 2, r0, r1, n, t); idle(3);
        total++; if (acertos !== 5'd3 || erros !== 5'd0) begin
            bad++; $display("FAIL eval_counts: got %0d/%0d expected 3/0", acertos, erros); end
        total++; if (rv_cnt !== 3 || pronto_cnt !== 1) begin
            bad++; $display("FAIL eval_pulses: got rv=%0d pronto=%0d expected 3/1", rv_cnt, pronto_cnt); end
    endtask

    task automatic test_tempo_err;
        logic r0, r1, n, t;
        do_start(1'b0, 1'b0, 4'd2);
        press(12'h008, 2, r0, r1, n, t); idle(18);
        press(12'h020, 2, r0, r1, n, t);
        total++; if (n !== 1'b1 || t !== 1'b0) begin
            bad++; $display("FAIL terr_late: got nota=%0b tempo=%0b expected 1/0", n, t); end
        idle(10);
        // 12 cycles -> 3 ticks vs stored 2: exactly at the tolerance edge.
        press(12'h001, 2, r0, r1, n, t);
        total++; if (n !== 1'b1 || t !== 1'b1) begin
            bad++; $display("FAIL terr_tol_edge: got nota=%0b tempo=%0b expected 1/1", n, t); end
        idle(3);
        total++; if (acertos !== 5'd2 || erros !== 5'd1) begin
            bad++; $display("FAIL terr_counts: got %0d/%0d expected 2/1", acertos, erros); end
    endtask

    task automatic test_timeout;
        int waited;
        do_start(1'b0, 1'b0, 4'd2);
        waited = 0;
        while (pronto !== 1'b1 && waited < 80) begin
            @(negedge clock);
            waited++;
        end
        total++; if (waited < 40 || waited > 42) begin
            bad++; $display("FAIL to_cycles: got %0d expected 40..42", waited); end
        total++; if (timeout !== 1'b1 || ocupado !== 1'b0 || endereco !== 4'd0) begin
            bad++; $display("FAIL to_flags: got timeout=%0b ocupado=%0b end=%0d expected 1/0/0",
                timeout, ocupado, endereco); end
        idle(2);
        total++; if (timeout !== 1'b1) begin
            bad++; $display("FAIL to_sticky: got %0b expected 1", timeout); end
        do_start(1'b0, 1'b0, 4'd2);
        total++; if (timeout !== 1'b0 || ocupado !== 1'b1) begin
            bad++; $display("FAIL to_restart: got timeout=%0b ocupado=%0b expected 0/1", timeout, ocupado); end
        reset = 1'b0; @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic r0, r1, n, t;
        do_start(1'b0, 1'b0, 4'd2);
        botoes = 12'h008;
        @(negedge clock);
        total++; if (db_estado !== 3'd2) begin
            bad++; $display("FAIL rmid_avalia: got %0d expected 2", db_estado); end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1; botoes = 12'd0;
        total++; if (resultado_valido !== 1'b0 || ocupado !== 1'b0 || db_estado !== 3'd0 || acertos !== 5'd0) begin
            bad++; $display("FAIL rmid_cleared: got rv=%0b ocupado=%0b estado=%0d acertos=%0d expected 0/0/0/0",
                resultado_valido, ocupado, db_estado, acertos); end
        idle(2);
        do_start(1'b0, 1'b0, 4'd2);
        press(12'h008, 2, r0, r1, n, t); idle(10);
        press(12'h020, 2, r0, r1, n, t); idle(6);
        press(12'h001, 2, r0, r1, n, t); idle(3);
        total++; if (acertos !== 5'd3 || erros !== 5'd0 || rv_cnt !== 3) begin
            bad++; $display("FAIL rmid_eval: got %0d/%0d rv=%0d expected 3/0 rv=3", acertos, erros, rv_cnt); end
        check_memory("rmid");
    endtask

    task automatic test_multikey;
        logic r0, r1, n, t;
        // Record: key 2 held 6 cycles (one event only), then key 0 12 cycles later.
        do_start(1'b1, 1'b0, 4'd1);
        press(12'h004, 6, r0, r1, n, t); idle(6);
        press(12'h001, 2, r0, r1, n, t); idle(3);
        total++; if (endereco !== 4'd1 || pronto_cnt !== 1) begin
            bad++; $display("FAIL mk_rec: got end=%0d pronto=%0d expected 1/1", endereco, pronto_cnt); end
        total++; if (dut.mem_nota_r[0] !== 4'd3 || dut.mem_nota_r[1] !== 4'd1 || dut.mem_tempo_r[1] !== 4'd3) begin
            bad++; $display("FAIL mk_mem: got n0=%0d n1=%0d t1=%0d expected 3/1/3",
                dut.mem_nota_r[0], dut.mem_nota_r[1], dut.mem_tempo_r[1]); end
        do_start(1'b0, 1'b0, 4'd1);
        press(12'h084, 2, r0, r1, n, t);
        total++; if (r1 !== 1'b1 || n !== 1'b1) begin
            bad++; $display("FAIL mk_lowest: got rv=%0b nota=%0b expected 1/1", r1, n); end
        idle(10);
        press(12'h001, 2, r0, r1, n, t); idle(3);
        total++; if (acertos !== 5'd2 || erros !== 5'd0) begin
            bad++; $display("FAIL mk_counts: got %0d/%0d expected 2/0", acertos, erros); end
    endtask

    task automatic test_restart;
        logic r0, r1, n, t;
        int waited;
        rv_cnt = 0; pronto_cnt = 0;
        modo_grava = 1'b0; rapido = 1'b0; ultimo = 4'd0;
        iniciar = 1'b1;
        @(negedge clock);
        press(12'h004, 2, r0, r1, n, t);
        waited = 0;
        while (pronto !== 1'b1 && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        total++; if (pronto !== 1'b1 || acertos !== 5'd1) begin
            bad++; $display("FAIL rs_first: got pronto=%0b acertos=%0d expected 1/1", pronto, acertos); end
        idle(2);
        total++; if (ocupado !== 1'b1 || db_estado !== 3'd1 || acertos !== 5'd0) begin
            bad++; $display("FAIL rs_again: got ocupado=%0b estado=%0d acertos=%0d expected 1/1/0",
                ocupado, db_estado, acertos); end
        iniciar = 1'b0;
        reset = 1'b0; @(negedge clock); reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_record();
        test_evaluate();
        test_tempo_err();
        test_timeout();
        test_reset_mid();
        test_multikey();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
